drygascon_bdo_unit: RTL

//  Output stage downstream of the DryGASCON core. Accepts one 128-bit squeezed rate block plus the matching

---
 rtl/drygascon_pkg.sv | 23 ++
 rtl/drygascon_bytemask.sv | 20 ++
 rtl/drygascon_bdo_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/drygascon_pkg.sv
// Shared constants for the DryGASCON output stage: op codes, bdo type codes,
// block geometry and the output-stage FSM state encoding.
// Ports: none (package).
package drygascon_pkg;

    localparam logic [1:0] OP_ENC     = 2'd0;
    localparam logic [1:0] OP_DEC     = 2'd1;
    localparam logic [1:0] OP_TAG_OUT = 2'd2;
    localparam logic [1:0] OP_TAG_CHK = 2'd3;

    localparam logic [3:0] BDO_PT  = 4'b0100;
    localparam logic [3:0] BDO_CT  = 4'b0101;
    localparam logic [3:0] BDO_TAG = 4'b1000;

    localparam int BLK_BYTES = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_AUTH = 2'd2
    } state_t;

endpackage

// File: rtl/drygascon_bytemask.sv
// Byte-count to MSB-first byte mask; bit 15 covers byte 0 (block MSBs).
// Ports: nbytes (0..16, larger values saturate to all ones) -> mask.
// Combinational, no state.
module drygascon_bytemask
    import drygascon_pkg::*;
(
    input  logic [4:0]           nbytes,
    output logic [BLK_BYTES-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (i < int'(nbytes)) begin
                mask[BLK_BYTES-1-i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drygascon_bdo_unit.sv
// DryGASCON output stage: rate^data (ENC/DEC), tag output, or tag check,
// serialised onto a CCW-wide bdo bus. First word one cycle after block accept.
// bdo outputs are registered and held while bdo_ready is low; blk_ready only in idle.
// Ports: clk/rst (async active-low); blk_* block input handshake; bdo_* word
// output handshake with type/byte-mask/end_of_block; msg_auth_* tag-check result.
module drygascon_bdo_unit
    import drygascon_pkg::*;
#(
    parameter int CCW     = 32,
    parameter int CCWdiv8 = CCW / 8,
    parameter int BLK     = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLK-1:0]     blk_r,
    input  logic [BLK-1:0]     blk_d,
    input  logic [4:0]         blk_nbytes,
    input  logic [1:0]         blk_op,
    input  logic               blk_eot,
    input  logic               blk_valid,
    output logic               blk_ready,
    output logic [CCW-1:0]     bdo,
    output logic               bdo_valid,
    input  logic               bdo_ready,
    output logic [3:0]         bdo_type,
    output logic [CCWdiv8-1:0] bdo_valid_bytes,
    output logic               end_of_block,
    output logic               msg_auth_valid,
    input  logic               msg_auth_ready,
    output logic               msg_auth
);

    localparam int NWORDS = BLK / CCW;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    function automatic logic [CCW-1:0] word_at(input logic [BLK-1:0] r,
                                               input logic [CW-1:0]  k);
        return r[BLK-1-int'(k)*CCW -: CCW];
    endfunction

    // n+1 leading ones, MSB-first (n = (nbytes-1) % CCWdiv8).
    function automatic logic [CCWdiv8-1:0] lead_ones(input int n);
        logic [CCWdiv8-1:0] m;
        m = '0;
        for (int i = 0; i < CCWdiv8; i++) begin
            if (i <= n) begin
                m[CCWdiv8-1-i] = 1'b1;
            end
        end
        return m;
    endfunction

    state_t             state_q, state_d;
    logic [BLK-1:0]     res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      last_idx_q, last_idx_d;
    logic [CCWdiv8-1:0] last_vb_q, last_vb_d;
    logic               eob_flag_q, eob_flag_d;
    logic [CCW-1:0]     bdo_q, bdo_d;
    logic               bdo_valid_q, bdo_valid_d;
    logic [3:0]         bdo_type_q, bdo_type_d;
    logic [CCWdiv8-1:0] bdo_vb_q, bdo_vb_d;
    logic               eob_q, eob_d;
    logic               auth_valid_q, auth_valid_d;
    logic               auth_q, auth_d;

    logic [4:0]           nb_eff;
    logic [4:0]           nb_m1;
    logic [BLK_BYTES-1:0] byte_mask;
    logic [BLK-1:0]       data_mask;
    logic [BLK-1:0]       xor_blk;
    logic [CW-1:0]        last_idx_new;
    logic [CCWdiv8-1:0]   last_vb_new;
    logic                 start_out;
    logic [CW-1:0]        cnt_nxt;

    // Tag ops always cover the full block; oversize counts saturate.
    always_comb begin
        if (blk_op == OP_TAG_OUT || blk_op == OP_TAG_CHK) begin
            nb_eff = 5'(BLK_BYTES);
        end else if (blk_nbytes > 5'(BLK_BYTES)) begin
            nb_eff = 5'(BLK_BYTES);
        end else begin
            nb_eff = blk_nbytes;
        end
    end

    drygascon_bytemask u_bytemask (
        .nbytes (nb_eff),
        .mask   (byte_mask)
    );

    always_comb begin
        data_mask = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            data_mask[i*8 +: 8] = {8{byte_mask[i]}};
        end
    end

    assign xor_blk      = blk_r ^ blk_d;
    assign nb_m1        = nb_eff - 5'd1;
    assign last_idx_new = CW'(int'(nb_m1) / CCWdiv8);
    assign last_vb_new  = lead_ones(int'(nb_m1) % CCWdiv8);
    assign cnt_nxt      = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        last_idx_d   = last_idx_q;
        last_vb_d    = last_vb_q;
        eob_flag_d   = eob_flag_q;
        bdo_d        = bdo_q;
        bdo_valid_d  = bdo_valid_q;
        bdo_type_d   = bdo_type_q;
        bdo_vb_d     = bdo_vb_q;
        eob_d        = eob_q;
        auth_valid_d = auth_valid_q;
        auth_d       = auth_q;
        start_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    case (blk_op)
                        OP_TAG_CHK: begin
                            // Full-width reduction, no early exit on first mismatch.
                            auth_d       = ~|xor_blk;
                            auth_valid_d = 1'b1;
                            state_d      = S_AUTH;
                        end
                        OP_TAG_OUT: begin
                            res_d      = blk_r;
                            bdo_type_d = BDO_TAG;
                            eob_flag_d = 1'b1;
                            start_out  = 1'b1;
                        end
                        default: begin
                            if (nb_eff != 5'd0) begin
                                res_d      = xor_blk & data_mask;
                                bdo_type_d = (blk_op == OP_ENC) ? BDO_CT : BDO_PT;
                                eob_flag_d = blk_eot;
                                start_out  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_OUT: begin
                if (bdo_ready) begin
                    if (cnt_q == last_idx_q) begin
                        bdo_valid_d = 1'b0;
                        eob_d       = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d    = cnt_nxt;
                        bdo_d    = word_at(res_q, cnt_nxt);
                        bdo_vb_d = (cnt_nxt == last_idx_q) ? last_vb_q : '1;
                        eob_d    = (cnt_nxt == last_idx_q) && eob_flag_q;
                    end
                end
            end
            S_AUTH: begin
                if (msg_auth_ready) begin
                    auth_valid_d = 1'b0;
                    auth_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Word 0 is loaded at accept so it is on the bus the next cycle.
        if (start_out) begin
            state_d     = S_OUT;
            cnt_d       = '0;
            last_idx_d  = last_idx_new;
            last_vb_d   = last_vb_new;
            bdo_d       = word_at(res_d, '0);
            bdo_valid_d = 1'b1;
            bdo_vb_d    = (last_idx_new == '0) ? last_vb_new : '1;
            eob_d       = (last_idx_new == '0) && eob_flag_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            res_q        <= '0;
            cnt_q        <= '0;
            last_idx_q   <= '0;
            last_vb_q    <= '0;
            eob_flag_q   <= 1'b0;
            bdo_q        <= '0;
            bdo_valid_q  <= 1'b0;
            bdo_type_q   <= '0;
            bdo_vb_q     <= '0;
            eob_q        <= 1'b0;
            auth_valid_q <= 1'b0;
            auth_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            last_idx_q   <= last_idx_d;
            last_vb_q    <= last_vb_d;
            eob_flag_q   <= eob_flag_d;
            bdo_q        <= bdo_d;
            bdo_valid_q  <= bdo_valid_d;
            bdo_type_q   <= bdo_type_d;
            bdo_vb_q     <= bdo_vb_d;
            eob_q        <= eob_d;
            auth_valid_q <= auth_valid_d;
            auth_q       <= auth_d;
        end
    end

    assign blk_ready       = (state_q == S_IDLE);
    assign bdo             = bdo_q;
    assign bdo_valid       = bdo_valid_q;
    assign bdo_type        = bdo_type_q;
    assign bdo_valid_bytes = bdo_vb_q;
    assign end_of_block    = eob_q;
    assign msg_auth_valid  = auth_valid_q;
    assign msg_auth        = auth_q;

endmodule
